// File: rtl/bsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bsa_pkg
//  Description : Shared definitions for byte_serial_adder (byte width and
//                FSM state encoding).
//  Revision    : 1.0  initial release
// ============================================================================
package bsa_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bsa_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_serial_adder_cra.sv
`default_nettype none
// ============================================================================
//  Module      : CRA
//  Description : 8-bit carry-ripple adder, sum[8] is carry-out.
//  Ports       : A, B  - 8-bit addends
//                cIn   - carry-in
//                sum   - 9-bit result {cout, sum[7:0]}
//  Revision    : 1.0  initial release
// ============================================================================
module CRA (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       cIn,
    output logic [8:0] sum
);

    logic [8:0] w_c;

    assign w_c[0] = cIn;

    genvar i;
    for (i = 0; i < 8; i++) begin : g_bit
        assign sum[i]   = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign sum[8] = w_c[8];

endmodule
`default_nettype wire

// File: rtl/byte_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serial_adder
//  Description : Adds two NBYTES-wide operands one byte per clock through a
//                single 8-bit ripple slice, LSB first, with a registered carry
//                between bytes. Result = in_a + in_b + in_cin, 8*NBYTES+1 bits.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid/in_ready, in_a, in_b, in_cin   - operand handshake
//                out_valid/out_ready, out_sum            - result handshake
//                out_ovf  - signed overflow, present only when the macro
//                           BSA_OVERFLOW_EN is defined
//  Revision    : 1.0  initial release
// ============================================================================
module byte_serial_adder
    import bsa_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NBYTES-1:0]    in_a,
    input  logic [8*NBYTES-1:0]    in_b,
    input  logic                   in_cin,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef BSA_OVERFLOW_EN
    output logic                   out_ovf,
`endif
    output logic [8*NBYTES:0]      out_sum
);

    localparam int                c_cnt_w = $clog2(NBYTES > 1 ? NBYTES : 2);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NBYTES - 1);

    bsa_state_t              r_state;
    bsa_state_t              w_state_nxt;
    logic [8*NBYTES-1:0]     r_a;
    logic [8*NBYTES-1:0]     r_b;
    logic                    r_carry;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [8*NBYTES:0]       r_sum;
    logic [BYTE_W-1:0]       w_a;
    logic [BYTE_W-1:0]       w_b;
    logic [BYTE_W:0]         w_slice;
    int                      w_off;

    // Bit offset of the byte currently in the slice.
    assign w_off = int'(r_cnt) * BYTE_W;
    assign w_a   = r_a[w_off +: BYTE_W];
    assign w_b   = r_b[w_off +: BYTE_W];

    CRA u_slice (
        .A   (w_a),
        .B   (w_b),
        .cIn (r_carry),
        .sum (w_slice)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // in_valid is deliberately ignored outside IDLE, even while leaving DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)        w_state_nxt = RUN;
            RUN:     if (r_cnt == c_last) w_state_nxt = DONE;
            DONE:    if (out_ready)       w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sum[w_off +: BYTE_W] <= w_slice[BYTE_W-1:0];
                    r_carry                <= w_slice[BYTE_W];
                    if (r_cnt == c_last) begin
                        r_sum[8*NBYTES] <= w_slice[BYTE_W];
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BSA_OVERFLOW_EN
    logic r_ovf;

    // Overflow = carry into MSB xor carry out of MSB; carry-in to bit 7 is
    // recovered as a7 ^ b7 ^ s7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && r_cnt == c_last) begin
            r_ovf <= w_a[BYTE_W-1] ^ w_b[BYTE_W-1] ^ w_slice[BYTE_W-1] ^ w_slice[BYTE_W];
        end
    end

    assign out_ovf = r_ovf;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_sum   = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_byte_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_serial_adder
//  Description : Directed self-checking bench for byte_serial_adder, one
//                NBYTES=4 instance and one NBYTES=1 instance. Overflow checks
//                are included when BSA_OVERFLOW_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_byte_serial_adder;

    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;

    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [8*NB-1:0] in_a = '0;
    logic [8*NB-1:0] in_b = '0;
    logic            in_cin = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [8*NB:0]   out_sum;
    logic            out_ovf;

    logic            in_valid1 = 1'b0;
    logic            in_ready1;
    logic [7:0]      in_a1 = '0;
    logic [7:0]      in_b1 = '0;
    logic            in_cin1 = 1'b0;
    logic            out_valid1;
    logic            out_ready1 = 1'b0;
    logic [8:0]      out_sum1;
    logic            out_ovf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    byte_serial_adder #(.NBYTES(NB)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BSA_OVERFLOW_EN
        .out_ovf   (out_ovf),
`endif
        .out_sum   (out_sum)
    );

    byte_serial_adder #(.NBYTES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a1),
        .in_b      (in_b1),
        .in_cin    (in_cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
`ifdef BSA_OVERFLOW_EN
        .out_ovf   (out_ovf1),
`endif
        .out_sum   (out_sum1)
    );

`ifndef BSA_OVERFLOW_EN
    assign out_ovf  = 1'b0;
    assign out_ovf1 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with in_ready expected high; returns at the first
    // negedge where out_valid is seen (or after the cycle budget expires).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          output int lat);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ov_low"}, 64'(out_valid), 64'd0);
        chk({tag, "_ir_high"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic [32:0] held;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Byte-0 carry into byte 1
        run_op(32'h000000FF, 32'h00000001, 1'b0, lat);
        chk("t1_lat", 64'(lat), 64'd4);
        chk("t1_sum", 64'(out_sum), 64'h000000100);
`ifdef BSA_OVERFLOW_EN
        chk("t1_ovf", 64'(out_ovf), 64'd0);
`endif
        release_result("t1");

        // Carry-in rippling through all bytes to the final carry-out
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, lat);
        chk("t2_lat", 64'(lat), 64'd4);
        chk("t2_sum", 64'(out_sum), 64'h100000000);
`ifdef BSA_OVERFLOW_EN
        chk("t2_ovf", 64'(out_ovf), 64'd0);
`endif
        release_result("t2");

        // Positive overflow into the sign bit
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
        chk("t3_lat", 64'(lat), 64'd4);
        chk("t3_sum", 64'(out_sum), 64'h080000000);
`ifdef BSA_OVERFLOW_EN
        chk("t3_ovf", 64'(out_ovf), 64'd1);
`endif

        // Back-pressure in DONE with new operands offered
        held     = out_sum;
        in_a     = 32'hDEADBEEF;
        in_b     = 32'h01020304;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_ov", 64'(out_valid), 64'd1);
            chk("hold_ir", 64'(in_ready), 64'd0);
            chk("hold_sum", 64'(out_sum), 64'(held));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hs_ov_low", 64'(out_valid), 64'd0);
        chk("hs_ir_high", 64'(in_ready), 64'd1);
        chk("hs_sum_kept", 64'(out_sum), 64'(held));
        run_op(32'hDEADBEEF, 32'h01020304, 1'b1, lat);
        chk("t4_lat", 64'(lat), 64'd4);
        chk("t4_sum", 64'(out_sum), 64'h0DFAFC1F4);
`ifdef BSA_OVERFLOW_EN
        chk("t4_ovf", 64'(out_ovf), 64'd0);
`endif
        release_result("t4");

        // Reset in the middle of RUN
        in_a     = 32'hAAAAAAAA;
        in_b     = 32'h55555555;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_ir_busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(out_sum), 64'd0);
        chk("mid_rst_ir", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'h12345678, 32'h11111111, 1'b0, lat);
        chk("t5_lat", 64'(lat), 64'd4);
        chk("t5_sum", 64'(out_sum), 64'h023456789);
`ifdef BSA_OVERFLOW_EN
        chk("t5_ovf", 64'(out_ovf), 64'd0);
`endif
        release_result("t5");

        // Single-byte instance
        in_a1     = 8'h80;
        in_b1     = 8'h80;
        in_cin1   = 1'b0;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("n1_lat", 64'(lat), 64'd1);
        chk("n1_sum", 64'(out_sum1), 64'h100);
`ifdef BSA_OVERFLOW_EN
        chk("n1_ovf", 64'(out_ovf1), 64'd1);
`endif
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        chk("n1_ir_high", 64'(in_ready1), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
